// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer; lookup response registered 1 cycle after request, no backpressure (a lookup and an update are accepted every cycle).
// Define BTB_UPDATE_BYPASS_EN to forward a same-cycle, same-index update into the lookup response.
module btb_table #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            btb_clk,
  input  logic            btb_rst_n,
  input  logic            btb_flush,
  input  logic            btb_lookup_valid,
  input  logic [PC_W-1:0] btb_lookup_pc,
  output logic            btb_resp_valid,
  output logic            btb_hit,
  output logic            btb_pred_taken,
  output logic [PC_W-1:0] btb_pred_target,
  input  logic            btb_update_valid,
  input  logic [PC_W-1:0] btb_update_pc,
  input  logic            btb_update_taken,
  input  logic [PC_W-1:0] btb_update_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic               r_resp_valid;
  logic               r_hit;
  logic               r_pred_taken;
  logic [PC_W-1:0]    r_pred_target;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_up_we;
  logic               w_nxt_valid;
  logic [TAG_W-1:0]   w_nxt_tag;
  logic [PC_W-1:0]    w_nxt_target;
  logic [1:0]         w_nxt_ctr;
  logic               w_lk_valid;
  logic [TAG_W-1:0]   w_lk_etag;
  logic [PC_W-1:0]    w_lk_target;
  logic [1:0]         w_lk_ctr;
  logic               w_lk_hit;
  logic               w_unused;

  assign w_lk_idx = btb_lookup_pc[IDX_W+1:2];
  assign w_lk_tag = btb_lookup_pc[PC_W-1:IDX_W+2];
  assign w_up_idx = btb_update_pc[IDX_W+1:2];
  assign w_up_tag = btb_update_pc[PC_W-1:IDX_W+2];
  assign w_unused = ^{btb_lookup_pc[1:0], btb_update_pc[1:0]};

  // Post-update image of the entry at the update index; shared by the table write and the bypass.
  always_comb begin
    w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    w_nxt_valid  = r_valid[w_up_idx];
    w_nxt_tag    = r_tag[w_up_idx];
    w_nxt_target = r_target[w_up_idx];
    w_nxt_ctr    = r_ctr[w_up_idx];
    w_up_we      = 1'b0;
    if (btb_update_valid && !btb_flush) begin
      if (w_up_hit) begin
        w_up_we = 1'b1;
        if (btb_update_taken) begin
          w_nxt_ctr    = (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
          w_nxt_target = btb_update_target;
        end else begin
          w_nxt_ctr = (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
        end
      end else if (btb_update_taken) begin
        w_up_we      = 1'b1;
        w_nxt_valid  = 1'b1;
        w_nxt_tag    = w_up_tag;
        w_nxt_target = btb_update_target;
        w_nxt_ctr    = 2'b10;
      end
    end
  end

  always_comb begin
    w_lk_valid  = r_valid[w_lk_idx];
    w_lk_etag   = r_tag[w_lk_idx];
    w_lk_target = r_target[w_lk_idx];
    w_lk_ctr    = r_ctr[w_lk_idx];
`ifdef BTB_UPDATE_BYPASS_EN
    if (w_up_we && (w_up_idx == w_lk_idx)) begin
      w_lk_valid  = w_nxt_valid;
      w_lk_etag   = w_nxt_tag;
      w_lk_target = w_nxt_target;
      w_lk_ctr    = w_nxt_ctr;
    end
`endif
    w_lk_hit = btb_lookup_valid && !btb_flush && w_lk_valid && (w_lk_etag == w_lk_tag);
  end

  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (btb_flush) begin
      r_valid <= '0;
    end else if (w_up_we) begin
      r_valid[w_up_idx]  <= w_nxt_valid;
      r_tag[w_up_idx]    <= w_nxt_tag;
      r_target[w_up_idx] <= w_nxt_target;
      r_ctr[w_up_idx]    <= w_nxt_ctr;
    end
  end

  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      r_resp_valid  <= 1'b0;
      r_hit         <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_resp_valid  <= btb_lookup_valid;
      r_hit         <= w_lk_hit;
      r_pred_taken  <= w_lk_hit && w_lk_ctr[1];
      r_pred_target <= w_lk_hit ? w_lk_target : '0;
    end
  end

  assign btb_resp_valid  = r_resp_valid;
  assign btb_hit         = r_hit;
  assign btb_pred_taken  = r_pred_taken;
  assign btb_pred_target = r_pred_target;

endmodule

// File: tb/tb_btb_table.sv
// Directed bench for btb_table: lookups, counter walk, aliasing, same-cycle update, flush and async reset.
module tb_btb_table;

  logic        btb_clk;
  logic        btb_rst_n;
  logic        btb_flush;
  logic        btb_lookup_valid;
  logic [31:0] btb_lookup_pc;
  logic        btb_resp_valid;
  logic        btb_hit;
  logic        btb_pred_taken;
  logic [31:0] btb_pred_target;
  logic        btb_update_valid;
  logic [31:0] btb_update_pc;
  logic        btb_update_taken;
  logic [31:0] btb_update_target;

  int checks   = 0;
  int failures = 0;

  // Response vector: {resp_valid, hit, pred_taken, pred_target}
  logic [34:0] got;
  localparam logic [34:0] MISS = {3'b100, 32'h0};

  btb_table #(.ENTRIES(16), .PC_W(32)) dut (
    .btb_clk          (btb_clk),
    .btb_rst_n        (btb_rst_n),
    .btb_flush        (btb_flush),
    .btb_lookup_valid (btb_lookup_valid),
    .btb_lookup_pc    (btb_lookup_pc),
    .btb_resp_valid   (btb_resp_valid),
    .btb_hit          (btb_hit),
    .btb_pred_taken   (btb_pred_taken),
    .btb_pred_target  (btb_pred_target),
    .btb_update_valid (btb_update_valid),
    .btb_update_pc    (btb_update_pc),
    .btb_update_taken (btb_update_taken),
    .btb_update_target(btb_update_target)
  );

  initial btb_clk = 1'b0;
  always #5 btb_clk = ~btb_clk;

  function automatic logic [34:0] resp();
    return {btb_resp_valid, btb_hit, btb_pred_taken, btb_pred_target};
  endfunction

  // All drivers start and end on a falling edge.
  task automatic do_lookup(input logic [31:0] pc, output logic [34:0] r);
    btb_lookup_valid = 1'b1;
    btb_lookup_pc    = pc;
    @(posedge btb_clk);
    @(negedge btb_clk);
    btb_lookup_valid = 1'b0;
    r = resp();
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    btb_update_valid  = 1'b1;
    btb_update_pc     = pc;
    btb_update_taken  = tk;
    btb_update_target = tgt;
    @(posedge btb_clk);
    @(negedge btb_clk);
    btb_update_valid = 1'b0;
  endtask

  task automatic do_flush();
    btb_flush = 1'b1;
    @(posedge btb_clk);
    @(negedge btb_clk);
    btb_flush = 1'b0;
  endtask

  task automatic test_reset();
    btb_rst_n = 1'b0;
    btb_flush = 1'b0;
    btb_lookup_valid = 1'b0;
    btb_lookup_pc = '0;
    btb_update_valid = 1'b0;
    btb_update_pc = '0;
    btb_update_taken = 1'b0;
    btb_update_target = '0;
    #2;
    got = resp();
    checks++; if (got !== 35'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 35'h0); end
    repeat (2) @(negedge btb_clk);
    btb_rst_n = 1'b1;
    @(negedge btb_clk);
    got = resp();
    checks++; if (got !== 35'h0) begin failures++; $display("FAIL idle_after_reset got=%h exp=%h", got, 35'h0); end
  endtask

  task automatic test_cold();
    do_lookup(32'h40, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL cold_lookup got=%h exp=%h", got, MISS); end
  endtask

  task automatic test_counter();
    do_update(32'h40, 1'b1, 32'h100);
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b111, 32'h100}) begin failures++; $display("FAIL alloc_ctr10 got=%h exp=%h", got, {3'b111, 32'h100}); end
    do_update(32'h40, 1'b1, 32'h100);
    do_update(32'h40, 1'b1, 32'h100);
    do_update(32'h40, 1'b1, 32'h180);
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b111, 32'h180}) begin failures++; $display("FAIL ctr11_new_target got=%h exp=%h", got, {3'b111, 32'h180}); end
    do_update(32'h40, 1'b0, 32'h999);
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b111, 32'h180}) begin failures++; $display("FAIL sat11_then_nt_ctr10 got=%h exp=%h", got, {3'b111, 32'h180}); end
    do_update(32'h40, 1'b0, 32'h999);
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b110, 32'h180}) begin failures++; $display("FAIL ctr01 got=%h exp=%h", got, {3'b110, 32'h180}); end
    do_update(32'h40, 1'b0, 32'h0);
    do_update(32'h40, 1'b0, 32'h0);
    do_update(32'h40, 1'b1, 32'h180);
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b110, 32'h180}) begin failures++; $display("FAIL sat00_then_t_ctr01 got=%h exp=%h", got, {3'b110, 32'h180}); end
    do_update(32'h40, 1'b1, 32'h180);
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b111, 32'h180}) begin failures++; $display("FAIL ctr10_again got=%h exp=%h", got, {3'b111, 32'h180}); end
  endtask

  task automatic test_alias();
    do_flush();
    do_update(32'h40, 1'b1, 32'h100);
    do_update(32'h80, 1'b1, 32'h200);
    do_lookup(32'h40, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL alias_evicted got=%h exp=%h", got, MISS); end
    do_lookup(32'h80, got);
    checks++; if (got !== {3'b111, 32'h200}) begin failures++; $display("FAIL alias_new got=%h exp=%h", got, {3'b111, 32'h200}); end
    do_update(32'hC4, 1'b0, 32'h500);
    do_lookup(32'hC4, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL nt_no_alloc got=%h exp=%h", got, MISS); end
  endtask

  task automatic test_same_cycle();
    logic [34:0] exp;
`ifdef BTB_UPDATE_BYPASS_EN
    exp = {3'b111, 32'h100};
`else
    exp = MISS;
`endif
    do_flush();
    btb_update_valid  = 1'b1;
    btb_update_pc     = 32'h40;
    btb_update_taken  = 1'b1;
    btb_update_target = 32'h100;
    do_lookup(32'h40, got);
    btb_update_valid = 1'b0;
    checks++; if (got !== exp) begin failures++; $display("FAIL same_cycle got=%h exp=%h", got, exp); end
    do_lookup(32'h40, got);
    checks++; if (got !== {3'b111, 32'h100}) begin failures++; $display("FAIL after_same_cycle got=%h exp=%h", got, {3'b111, 32'h100}); end
  endtask

  task automatic test_flush();
    do_update(32'h44, 1'b1, 32'h300);
    btb_flush         = 1'b1;
    btb_update_valid  = 1'b1;
    btb_update_pc     = 32'h48;
    btb_update_taken  = 1'b1;
    btb_update_target = 32'h400;
    do_lookup(32'h44, got);
    btb_flush        = 1'b0;
    btb_update_valid = 1'b0;
    checks++; if (got !== MISS) begin failures++; $display("FAIL lookup_in_flush got=%h exp=%h", got, MISS); end
    do_lookup(32'h40, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL flush_40 got=%h exp=%h", got, MISS); end
    do_lookup(32'h44, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL flush_44 got=%h exp=%h", got, MISS); end
    do_lookup(32'h48, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL flush_drops_update_48 got=%h exp=%h", got, MISS); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [34:0] exps [3];
    pcs[0] = 32'h40; exps[0] = {3'b111, 32'h100};
    pcs[1] = 32'h44; exps[1] = {3'b111, 32'h300};
    pcs[2] = 32'h50; exps[2] = MISS;
    do_update(32'h40, 1'b1, 32'h100);
    do_update(32'h44, 1'b1, 32'h300);
    btb_lookup_valid = 1'b1;
    btb_lookup_pc    = pcs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge btb_clk);
      @(negedge btb_clk);
      got = resp();
      if (i < 2) btb_lookup_pc = pcs[i+1];
      else btb_lookup_valid = 1'b0;
      checks++; if (got !== exps[i]) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, exps[i]); end
    end
    @(negedge btb_clk);
    got = resp();
    checks++; if (got !== 35'h0) begin failures++; $display("FAIL idle_resp got=%h exp=%h", got, 35'h0); end
  endtask

  task automatic test_reset_midstream();
    btb_lookup_valid = 1'b1;
    btb_lookup_pc    = 32'h40;
    @(posedge btb_clk);
    #2;
    btb_lookup_valid = 1'b0;
    got = resp();
    checks++; if (got !== {3'b111, 32'h100}) begin failures++; $display("FAIL pre_reset_resp got=%h exp=%h", got, {3'b111, 32'h100}); end
    btb_rst_n = 1'b0;
    #1;
    got = resp();
    checks++; if (got !== 35'h0) begin failures++; $display("FAIL async_reset_resp got=%h exp=%h", got, 35'h0); end
    @(negedge btb_clk);
    btb_rst_n = 1'b1;
    @(negedge btb_clk);
    do_lookup(32'h40, got);
    checks++; if (got !== MISS) begin failures++; $display("FAIL post_reset_lookup got=%h exp=%h", got, MISS); end
  endtask

  initial begin
    test_reset();
    test_cold();
    test_counter();
    test_alias();
    test_same_cycle();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
